div_unit_32bit: RTL and testbench

Iterative 32-bit integer divider implementing RV32M DIV/DIVU/REM/REMU for the execute path of the pipelined core. It sits directly upstream of the 32-bit enabled pipeline register: result_o drives that register's D input and valid_o drives its enable, so the register captures exactly one result per operation. busy_o feeds the hazard logic to stall earlier stages while a division is in flight.

---
 rtl/div_unit_32bit.sv | 131 +++++++++++++
 tb/tb_div_unit_32bit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/div_unit_32bit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring algorithm, one quotient bit per cycle.
// Zero-divisor and signed-overflow cases bypass the iteration and complete with latency 1.
module div_unit_32bit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned PW = XLEN + 1;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [XLEN-1:0]  quo_q;      // dividend bits shift out MSB-first, quotient bits shift in
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  divisor_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic [XLEN-1:0]  result_q;
  logic             valid_q;
  logic             busy_q;

  logic            signed_op;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            accept;
  logic [PW-1:0]   trial;
  logic [XLEN-1:0] fix_q;
  logic [XLEN-1:0] fix_r;

  // Operand conditioning and special-case detection on the raw inputs
  always_comb begin
    signed_op   = ~op_i[0];
    neg_a       = signed_op & rs1_i[XLEN-1];
    neg_b       = signed_op & rs2_i[XLEN-1];
    abs_a       = neg_a ? (~rs1_i + XLEN'(1)) : rs1_i;
    abs_b       = neg_b ? (~rs2_i + XLEN'(1)) : rs2_i;
    div_zero    = (rs2_i == '0);
    ovf         = signed_op && (rs1_i == MIN_INT) && (rs2_i == '1);
    special     = div_zero | ovf;
    if (div_zero) special_res = op_i[1] ? rs1_i : '1;
    else          special_res = op_i[1] ? '0 : MIN_INT;
    accept      = (state_q == S_IDLE) && start_i && !flush_i;
    trial       = {rem_q, quo_q[XLEN-1]} - {1'b0, divisor_q};
    fix_q       = sign_q_q ? (~quo_q + XLEN'(1)) : quo_q;
    fix_r       = sign_r_q ? (~rem_q + XLEN'(1)) : rem_q;
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == LAST_CNT) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      op_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= (state_q == S_DONE) && !flush_i;
      busy_q  <= (state_d == S_CALC) || (state_d == S_FIX);
      if (accept) begin
        op_q      <= op_i;
        quo_q     <= abs_a;
        divisor_q <= abs_b;
        rem_q     <= '0;
        cnt_q     <= '0;
        sign_q_q  <= signed_op & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
        sign_r_q  <= neg_a;
        if (special) result_q <= special_res;
      end else if (state_q == S_CALC && !flush_i) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (!trial[PW-1]) begin
          rem_q <= trial[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q <= {rem_q[XLEN-2:0], quo_q[XLEN-1]};
          quo_q <= {quo_q[XLEN-2:0], 1'b0};
        end
      end else if (state_q == S_FIX && !flush_i) begin
        result_q <= op_q[1] ? fix_r : fix_q;
      end
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit_32bit.sv
// Scoreboard bench for div_unit_32bit: driver queues expected result/edge/busy count,
// monitor checks each valid_o pulse against the queue head.
module tb_div_unit_32bit;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned busy_run = 0;
  logic [31:0] last_res = 32'd0;
  logic [31:0] q_res[$];
  int unsigned q_edge[$];
  int unsigned q_busy[$];

  div_unit_32bit dut (
    .clk(clk), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .flush_i(flush_i),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per valid_o pulse
  always @(negedge clk) begin
    logic [31:0] e_res;
    int unsigned e_edge;
    int unsigned e_busy;
    if (busy_o) busy_run++;
    if (valid_o) begin
      if (q_res.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e_res  = q_res.pop_front();
        e_edge = q_edge.pop_front();
        e_busy = q_busy.pop_front();
        check("result", result_o, e_res);
        check("latency_edge", 32'(cyc), 32'(e_edge));
        check("busy_cycles", 32'(busy_run), 32'(e_busy));
      end
      busy_run = 0;
    end
    if (flush_i || !rst_ni) busy_run = 0;
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int unsigned lat, input bit push);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
    if (push) begin
      q_res.push_back(exp);
      q_edge.push_back(cyc + 1 + lat);
      q_busy.push_back(lat == 1 ? 0 : 33);
      last_res = exp;
    end
    @(posedge clk); #1;
    start_i = 1'b0; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h0000_0001;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q_res.size() != 0; i++) @(posedge clk);
    check("drain_pending", 32'(q_res.size()), 32'd0);
  endtask

  task automatic op_chk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int unsigned lat);
    issue(op, a, b, exp, lat, 1'b1);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00; rs1_i = '0; rs2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    rst_ni = 1'b1;

    op_chk(DIVU, 32'd100, 32'd7, 32'd14, 34);
    op_chk(REMU, 32'd100, 32'd7, 32'd2, 34);
    op_chk(DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34);
    op_chk(REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34);
    op_chk(REM,  32'd100, 32'hFFFF_FFF9, 32'd2, 34);
    op_chk(DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    op_chk(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    op_chk(REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 34);
    op_chk(DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1);
    op_chk(REM,  32'd1234, 32'd0, 32'd1234, 1);
    op_chk(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    op_chk(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Flush mid-CALC: no pulse, result holds
    issue(DIVU, 32'd1000, 32'd3, 32'd0, 34, 1'b0);
    repeat (8) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    check("flush_busy", 32'(busy_o), 32'd0);
    repeat (40) @(posedge clk);
    #1 check("flush_result_hold", result_o, last_res);
    op_chk(DIVU, 32'd9, 32'd3, 32'd3, 34);

    // Start together with flush in IDLE is dropped
    @(posedge clk); #1;
    start_i = 1'b1; flush_i = 1'b1; op_i = DIVU; rs1_i = 32'd50; rs2_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_start_busy", 32'(busy_o), 32'd0);
    repeat (40) @(posedge clk);

    // Start while busy is ignored
    issue(DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1);
    repeat (5) @(posedge clk);
    #1 start_i = 1'b1; op_i = REMU; rs1_i = 32'd50; rs2_i = 32'd5;
    @(posedge clk); #1 start_i = 1'b0;
    drain();
    repeat (10) @(posedge clk);

    // Asynchronous reset mid-CALC
    issue(DIVU, 32'd1000, 32'd3, 32'd0, 34, 1'b0);
    repeat (10) @(posedge clk);
    #3 rst_ni = 1'b0;
    #1;
    check("midreset_busy", 32'(busy_o), 32'd0);
    check("midreset_valid", 32'(valid_o), 32'd0);
    check("midreset_result", result_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (40) @(posedge clk);
    op_chk(DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 34);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
